// File: rtl/id_ex_reg.sv
// ID->EX pipeline register for the five-stage RISC-V core.
// Captures the decoded instruction from Decode and presents it to Execute.
// Holds on StallE, loads a bubble on PipelineFlush or when ValidD is low.
// Optional saturating stall/flush event counters are built when the macro
// ID_EX_PERF_CNT_EN is defined; otherwise the counter ports read constant 0.
module id_ex_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallE,
  input  logic            PipelineFlush,
  input  logic            ValidD,
  input  logic [XLEN-1:0] PC_D,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [XLEN-1:0] ImmExt_D,
  input  logic [4:0]      Rs1_D,
  input  logic [4:0]      Rs2_D,
  input  logic [4:0]      Rd_D,
  input  logic            RegWriteD,
  input  logic            MemReadD,
  input  logic            MemWriteD,
  input  logic            ALUSrcD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic [3:0]      ALUControlD,
  input  logic [1:0]      ResultSrcD,
  output logic            ValidE,
  output logic [XLEN-1:0] PC_E,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] ImmExt_E,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      Rd_E,
  output logic            RegWriteE,
  output logic            MemReadE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [3:0]      ALUControlE,
  output logic [1:0]      ResultSrcE,
  input  logic            CntClr,
  output logic [15:0]     StallCnt,
  output logic [15:0]     FlushCnt
);

  // Whole E-stage payload kept as one packed word so a bubble is simply '0.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [3:0]      alu_ctrl;
    logic [1:0]      result_src;
  } stage_t;

  stage_t stage_d, stage_q;
  stage_t stage_in;

  // Gather the Decode-side fields into one payload word.
  always_comb begin
    stage_in            = '0;
    stage_in.valid      = 1'b1;
    stage_in.pc         = PC_D;
    stage_in.rd1        = RD1_D;
    stage_in.rd2        = RD2_D;
    stage_in.imm        = ImmExt_D;
    stage_in.rs1        = Rs1_D;
    stage_in.rs2        = Rs2_D;
    stage_in.rd         = Rd_D;
    stage_in.reg_write  = RegWriteD;
    stage_in.mem_read   = MemReadD;
    stage_in.mem_write  = MemWriteD;
    stage_in.alu_src    = ALUSrcD;
    stage_in.branch     = BranchD;
    stage_in.jump       = JumpD;
    stage_in.alu_ctrl   = ALUControlD;
    stage_in.result_src = ResultSrcD;
  end

  // Next-state select: flush > stall > load; an invalid decode loads a bubble
  // with data fields zeroed so it never matches a hazard comparison.
  always_comb begin
    stage_d = stage_q;
    if (PipelineFlush) begin
      stage_d = '0;
    end else if (!StallE) begin
      stage_d = ValidD ? stage_in : '0;
    end
  end

  // Pipeline state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ValidE      = stage_q.valid;
  assign PC_E        = stage_q.pc;
  assign RD1_E       = stage_q.rd1;
  assign RD2_E       = stage_q.rd2;
  assign ImmExt_E    = stage_q.imm;
  assign Rs1_E       = stage_q.rs1;
  assign Rs2_E       = stage_q.rs2;
  assign Rd_E        = stage_q.rd;
  assign RegWriteE   = stage_q.reg_write;
  assign MemReadE    = stage_q.mem_read;
  assign MemWriteE   = stage_q.mem_write;
  assign ALUSrcE     = stage_q.alu_src;
  assign BranchE     = stage_q.branch;
  assign JumpE       = stage_q.jump;
  assign ALUControlE = stage_q.alu_ctrl;
  assign ResultSrcE  = stage_q.result_src;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] flush_cnt_d, flush_cnt_q;
  logic        stall_evt, flush_evt;

  // A stall only counts when it is not overridden by a flush.
  assign stall_evt = StallE & ~PipelineFlush;
  assign flush_evt = PipelineFlush;

  // Counter next-state: clear beats increment, increments saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter state, cleared asynchronously with the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  // Counters not built: ports tied off, clear input intentionally ignored.
  logic unused_cnt_clr;
  assign unused_cnt_clr = CntClr;
  assign StallCnt       = '0;
  assign FlushCnt       = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: each driven cycle pushes its expected
// E-stage contents and counter values; they are popped after the edge.
module tb_id_ex_reg;

  localparam int unsigned XLEN = 32;
`ifdef ID_EX_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic            clk, rst;
  logic            StallE, PipelineFlush, ValidD;
  logic [XLEN-1:0] PC_D, RD1_D, RD2_D, ImmExt_D;
  logic [4:0]      Rs1_D, Rs2_D, Rd_D;
  logic            RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD;
  logic [3:0]      ALUControlD;
  logic [1:0]      ResultSrcD;
  logic            ValidE;
  logic [XLEN-1:0] PC_E, RD1_E, RD2_E, ImmExt_E;
  logic [4:0]      Rs1_E, Rs2_E, Rd_E;
  logic            RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [3:0]      ALUControlE;
  logic [1:0]      ResultSrcE;
  logic            CntClr;
  logic [15:0]     StallCnt, FlushCnt;

  id_ex_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .PipelineFlush(PipelineFlush), .ValidD(ValidD),
    .PC_D(PC_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD), .ResultSrcD(ResultSrcD),
    .ValidE(ValidE), .PC_E(PC_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
    .CntClr(CntClr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rd1, rd2, imm;
    logic [14:0]     regs;   // {rs1, rs2, rd}
    logic [11:0]     ctrl;   // {regwr, memrd, memwr, alusrc, br, jmp, aluctl, ressrc}
    logic [15:0]     stall_cnt, flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks, failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("valid", 64'(ValidE), 64'(e.valid));
    check("pc", 64'(PC_E), 64'(e.pc));
    check("rd1", 64'(RD1_E), 64'(e.rd1));
    check("rd2", 64'(RD2_E), 64'(e.rd2));
    check("imm", 64'(ImmExt_E), 64'(e.imm));
    check("regs", 64'({Rs1_E, Rs2_E, Rd_E}), 64'(e.regs));
    check("ctrl", 64'({RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE,
                       ALUControlE, ResultSrcE}), 64'(e.ctrl));
    check("stall_cnt", 64'(StallCnt), 64'(e.stall_cnt));
    check("flush_cnt", 64'(FlushCnt), 64'(e.flush_cnt));
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Expected contents after the next edge, from the inputs the bench drives.
  function automatic exp_t predict(input exp_t c);
    exp_t n;
    n = c;
    if (PipelineFlush || (!StallE && !ValidD)) begin
      n.valid = 1'b0; n.pc = '0; n.rd1 = '0; n.rd2 = '0; n.imm = '0; n.regs = '0; n.ctrl = '0;
    end else if (!StallE) begin
      n.valid = 1'b1; n.pc = PC_D; n.rd1 = RD1_D; n.rd2 = RD2_D; n.imm = ImmExt_D;
      n.regs  = {Rs1_D, Rs2_D, Rd_D};
      n.ctrl  = {RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD, ALUControlD, ResultSrcD};
    end
    if (!PerfEn) begin
      n.stall_cnt = '0; n.flush_cnt = '0;
    end else if (CntClr) begin
      n.stall_cnt = '0; n.flush_cnt = '0;
    end else begin
      if (PipelineFlush) n.flush_cnt = sat_inc(c.flush_cnt);
      else if (StallE)   n.stall_cnt = sat_inc(c.stall_cnt);
    end
    return n;
  endfunction

  // One clock: push expectation, advance, pop and (optionally) compare.
  task automatic step(input bit do_check);
    exp_t e;
    exp_q.push_back(predict(cur));
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    cur = e;
    if (do_check) check_all(e);
  endtask

  task automatic drive_idle();
    StallE = 0; PipelineFlush = 0; ValidD = 0; CntClr = 0;
    PC_D = '0; RD1_D = '0; RD2_D = '0; ImmExt_D = '0; Rs1_D = '0; Rs2_D = '0; Rd_D = '0;
    RegWriteD = 0; MemReadD = 0; MemWriteD = 0; ALUSrcD = 0; BranchD = 0; JumpD = 0;
    ALUControlD = '0; ResultSrcD = '0;
  endtask

  task automatic drive_random();
    ValidD = 1'b1;
    PC_D = $urandom; RD1_D = $urandom; RD2_D = $urandom; ImmExt_D = $urandom;
    Rs1_D = 5'($urandom); Rs2_D = 5'($urandom); Rd_D = 5'($urandom);
    {RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD} = 6'($urandom);
    ALUControlD = 4'($urandom); ResultSrcD = 2'($urandom);
  endtask

  initial begin
    checks = 0; failures = 0; cur = '0;
    drive_idle();
    rst = 1'b0;
    #12;
    check_all('0);                             // reset state
    #5 rst = 1'b1;                             // release between edges

    // Build up a nonzero flush count, then a load, then reset mid-cycle.
    PipelineFlush = 1; step(1'b1); PipelineFlush = 0;
    drive_random(); PC_D = 32'h100; RegWriteD = 1; Rd_D = 5'd5; step(1'b1);
    #3 rst = 1'b0;
    #1 check_all('0);
    cur = '0;
    #2 rst = 1'b1;

    // Plain load.
    drive_idle(); ValidD = 1; PC_D = 32'h200; Rs1_D = 5'd3; MemReadD = 1; step(1'b1);
    check("plain_pc", 64'(PC_E), 64'h200);

    // Stall hold for 3 edges, then capture.
    PC_D = 32'h204; StallE = 1;
    for (int i = 0; i < 3; i++) step(1'b1);
    check("stall_hold_pc", 64'(PC_E), 64'h200);
    check("stall_cnt3", 64'(StallCnt), PerfEn ? 64'd3 : 64'd0);
    StallE = 0; step(1'b1);
    check("after_stall_pc", 64'(PC_E), 64'h204);

    // Flush beats stall while E holds a load to x7.
    drive_idle(); ValidD = 1; PC_D = 32'h300; MemReadD = 1; RegWriteD = 1; Rd_D = 5'd7;
    ResultSrcD = 2'b01; step(1'b1);
    StallE = 1; PipelineFlush = 1; step(1'b1);
    StallE = 0; PipelineFlush = 0;

    // Invalid decode becomes a bubble.
    drive_idle(); ValidD = 0; RegWriteD = 1; Rd_D = 5'd9; PC_D = 32'h400; step(1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 40; i++) begin
      drive_random();
      ValidD        = ($urandom_range(0, 3) != 0);
      StallE        = ($urandom_range(0, 3) == 0);
      PipelineFlush = ($urandom_range(0, 5) == 0);
      CntClr        = ($urandom_range(0, 15) == 0);
      step(1'b1);
    end

    // Counter saturation: clear, preload FlushCnt to 0xFFFE, then 3 flushes.
    drive_idle(); CntClr = 1; step(1'b1); CntClr = 0;
    PipelineFlush = 1;
    for (int i = 0; i < 65534; i++) step(1'b0);
    check("flush_preload", 64'(FlushCnt), PerfEn ? 64'hFFFE : 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("flush_sat", 64'(FlushCnt), PerfEn ? 64'hFFFF : 64'd0);
    CntClr = 1; step(1'b1);
    check("flush_clr", 64'(FlushCnt), 64'd0);
    drive_idle(); step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID→EX pipeline register for the five-stage RISC-V core. Captures the decoded instruction from Decode and presents it to Execute. Holds its contents while `StallE` is high (load-use stall) and replaces its contents with a bubble on `PipelineFlush` (taken branch or jump). It is the source of `Rs1_E`, `Rs2_E` and the E-stage control bits that the hazard unit consumes. Optional saturating stall/flush event counters are included for performance bring-up.

## Interface
Parameters:
- `XLEN`, 32, datapath width of PC, operands and immediate

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `StallE`  in  1  hold current E contents
- `PipelineFlush`  in  1  load bubble into E
- `ValidD`  in  1  D holds a real instruction
- `PC_D`, `RD1_D`, `RD2_D`, `ImmExt_D`  in  XLEN each  PC, register-file read data, extended immediate
- `Rs1_D`, `Rs2_D`, `Rd_D`  in  5 each  register indices
- `RegWriteD`, `MemReadD`, `MemWriteD`, `ALUSrcD`, `BranchD`, `JumpD`  in  1 each  control bits
- `ALUControlD`  in  4  ALU operation
- `ResultSrcD`  in  2  writeback source select
- `ValidE`  out  1  E holds a real instruction
- `PC_E`, `RD1_E`, `RD2_E`, `ImmExt_E`  out  XLEN each  registered copies
- `Rs1_E`, `Rs2_E`, `Rd_E`  out  5 each  registered copies
- `RegWriteE`, `MemReadE`, `MemWriteE`, `ALUSrcE`, `BranchE`, `JumpE`  out  1 each  registered copies
- `ALUControlE`  out  4  registered copy
- `ResultSrcE`  out  2  registered copy
- `CntClr`  in  1  synchronous clear of both counters
- `StallCnt`  out  16  saturating count of stall cycles
- `FlushCnt`  out  16  saturating count of flush cycles

## Operation
- Per-edge update priority: reset > flush > stall > load.
- Reset (`rst`=0): every output goes to 0 immediately, without waiting for a clock edge. This includes the counters.
- Flush: all `*_E` outputs and `ValidE` load 0 on the next edge. The result is a bubble: no register write, no memory access, no branch, Rd/Rs = x0.
- Flush with stall: flush wins and a bubble is loaded.
- Stall without flush: all `*_E` outputs hold their values.
- Load: all `*_D` inputs are copied to `*_E`.
- Load with `ValidD`=0: a bubble is loaded, identical to the flush case. Data fields are also zeroed so that a bubble never matches a hazard comparison.
- `StallCnt`:
  - Increments on each edge where `StallE`=1 and `PipelineFlush`=0.
  - Saturates at 0xFFFF.
- `FlushCnt`:
  - Increments on each edge where `PipelineFlush`=1.
  - Saturates at 0xFFFF.
- `CntClr`: clears both counters on the next edge. It takes priority over increment. It does not affect pipeline contents.

## Timing
- Latency is 1 cycle from D inputs to E outputs.
- All outputs are driven directly from flops, with no combinational path from input to output.
- Stall and flush are sampled on the same edge as the data.
- A stall lasting N cycles keeps the E contents unchanged for N edges. The D contents are captured on the first edge after `StallE` drops.
- Reset deassertion is asynchronous. The first load occurs on the first rising edge with `rst`=1.
- Counter values are visible the cycle after the event.

## Configuration
- `ID_EX_PERF_CNT_EN`
  - Defined: `StallCnt`/`FlushCnt` logic is built as described above.
  - Undefined: ports remain in place, both counters are constant 0, `CntClr` is ignored, and no counter flops are generated.

## Test plan
- Reset mid-stream:
  - Load `PC_D`=0x100, `RegWriteD`=1, `Rd_D`=5, then pull `rst` low between edges.
  - Expected: all outputs read 0 before the next edge.
- Plain load:
  - `ValidD`=1, `PC_D`=0x200, `Rs1_D`=3, `MemReadD`=1.
  - Expected after one edge: `PC_E`=0x200, `Rs1_E`=3, `MemReadE`=1, `ValidE`=1.
- Stall hold:
  - E holds `PC_E`=0x200. Hold `StallE`=1 for 3 cycles while `PC_D`=0x204.
  - Expected: `PC_E` stays 0x200 for 3 edges and becomes 0x204 on the edge after `StallE` drops. With the macro defined, `StallCnt`=3.
- Flush beats stall:
  - `StallE`=1 and `PipelineFlush`=1 together while E holds a valid load to x7.
  - Expected: `ValidE`=0, `RegWriteE`=0, `MemReadE`=0, `Rd_E`=0, and `FlushCnt` increments by 1 while `StallCnt` does not.
- Invalid decode:
  - `ValidD`=0 with `RegWriteD`=1 and `Rd_D`=9.
  - Expected: `RegWriteE`=0, `Rd_E`=0, `ValidE`=0.
- Counters:
  - Preload `FlushCnt` to 0xFFFE, apply 3 flushes.
  - Expected: reads 0xFFFF. Then asserting `CntClr` together with a flush gives 0.
  - Without the macro: both counters read 0 throughout.
